// File: rtl/serial_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmd_pkg
// Purpose  : Frame/response byte constants, state encodings and a saturating
//            increment helper shared by the serial command sequencer.
// Options  : SERIAL_CMD_TIMEOUT_EN (used by serial_cmd_sequencer)
// Revision : 1.0 - initial release
// ============================================================================
package serial_cmd_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;   // 'R'
    localparam logic [7:0] OP_WRITE = 8'h57;   // 'W'
    localparam logic [7:0] RSP_ACK  = 8'h41;   // 'A'
    localparam logic [7:0] RSP_ERR  = 8'h45;   // 'E'

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_GET_ADDR   = 3'd1;
    localparam logic [2:0] ST_GET_DATA   = 3'd2;
    localparam logic [2:0] ST_REG_ACCESS = 3'd3;
    localparam logic [2:0] ST_REG_WAIT   = 3'd4;
    localparam logic [2:0] ST_SEND_BYTE  = 3'd5;
    localparam logic [2:0] ST_WAIT_COPY  = 3'd6;

    // Parser states; RESPOND covers the whole SEND_BYTE/WAIT_COPY phase that
    // the response sender owns.
    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        GET_ADDR   = ST_GET_ADDR,
        GET_DATA   = ST_GET_DATA,
        REG_ACCESS = ST_REG_ACCESS,
        REG_WAIT   = ST_REG_WAIT,
        RESPOND    = ST_SEND_BYTE
    } seq_state_t;

    // Response sender states.
    typedef enum logic [2:0] {
        TX_IDLE   = ST_IDLE,
        SEND_BYTE = ST_SEND_BYTE,
        WAIT_COPY = ST_WAIT_COPY
    } tx_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmd_sequencer_if
// Purpose  : Receiver, transmitter and register-bank signals of the serial
//            command sequencer. master = sequencer, slave = environment.
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
interface serial_cmd_sequencer_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_read;
    logic [7:0] tx_data;
    logic       tx_data_ready;
    logic       tx_data_copied;
    logic       tx_transaction;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    modport master (
        input  rx_valid, rx_data, rx_err, tx_data_copied, reg_rdata,
        output rx_read, tx_data, tx_data_ready, tx_transaction,
        output reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output rx_valid, rx_data, rx_err, tx_data_copied, reg_rdata,
        input  rx_read, tx_data, tx_data_ready, tx_transaction,
        input  reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface
`default_nettype wire

// File: rtl/serial_resp_sender.sv
`default_nettype none
// ============================================================================
// Module   : serial_resp_sender
// Purpose  : Buffers a 2- or 3-byte response and streams it byte by byte
//            through the transmitter ready/copied handshake.
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module serial_resp_sender
    import serial_cmd_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       start,
    input  wire logic       len3,
    input  wire logic [7:0] b0,
    input  wire logic [7:0] b1,
    input  wire logic [7:0] b2,
    input  wire logic       tx_data_copied,
    output logic [7:0]      tx_data,
    output logic            tx_data_ready,
    output logic            tx_transaction,
    output logic            done
);

    tx_state_t   state, state_nxt;
    logic [23:0] resp_buf, resp_buf_nxt;   // next byte to send sits in [7:0]
    logic [1:0]  left, left_nxt;           // bytes still to hand over
    logic [7:0]  data_nxt;
    logic        ready_nxt;
    logic        trans_nxt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TX_IDLE;
        else     state <= state_nxt;
    end

    // Datapath and handshake outputs, all registered so reset clears them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_buf       <= '0;
            left           <= '0;
            tx_data        <= '0;
            tx_data_ready  <= 1'b0;
            tx_transaction <= 1'b0;
        end else begin
            resp_buf       <= resp_buf_nxt;
            left           <= left_nxt;
            tx_data        <= data_nxt;
            tx_data_ready  <= ready_nxt;
            tx_transaction <= trans_nxt;
        end
    end

    // Next state: SEND_BYTE presents a byte, WAIT_COPY waits for the latch;
    // the return through SEND_BYTE guarantees a low ready cycle between bytes.
    always_comb begin
        state_nxt    = state;
        resp_buf_nxt = resp_buf;
        left_nxt     = left;
        data_nxt     = tx_data;
        ready_nxt    = tx_data_ready;
        trans_nxt    = tx_transaction;
        done         = 1'b0;
        case (state)
            TX_IDLE: begin
                if (start) begin
                    resp_buf_nxt = {b2, b1, b0};
                    left_nxt     = len3 ? 2'd3 : 2'd2;
                    trans_nxt    = 1'b1;
                    state_nxt    = SEND_BYTE;
                end
            end
            SEND_BYTE: begin
                data_nxt  = resp_buf[7:0];
                ready_nxt = 1'b1;
                state_nxt = WAIT_COPY;
            end
            WAIT_COPY: begin
                if (tx_data_copied) begin
                    ready_nxt = 1'b0;
                    if (left == 2'd1) begin
                        trans_nxt = 1'b0;
                        done      = 1'b1;
                        state_nxt = TX_IDLE;
                    end else begin
                        resp_buf_nxt = resp_buf >> 8;
                        left_nxt     = left - 2'd1;
                        state_nxt    = SEND_BYTE;
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/serial_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmd_sequencer
// Purpose  : Parses 'R' addr / 'W' addr data frames from the RS232 receiver,
//            performs one register access per frame and returns an 'A' or
//            'E' response through serial_resp_sender.
// Options  : SERIAL_CMD_TIMEOUT_EN - inter-byte timeout in GET_ADDR/GET_DATA
// Revision : 1.0 - initial release
// ============================================================================
module serial_cmd_sequencer
    import serial_cmd_pkg::*;
#(
    parameter int REG_COUNT      = 16,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    serial_cmd_sequencer_if.master bus,
    output logic                   busy,
    output logic [7:0]             err_cnt
);

    seq_state_t state, state_nxt;
    logic       is_write, is_write_nxt;
    logic [7:0] addr, addr_nxt;
    logic [7:0] wdata, wdata_nxt;
    logic       pop, pop_nxt;
    logic       we_strobe, we_nxt;
    logic       re_strobe, re_nxt;
    logic [7:0] err_count;
    logic       err_inc;
    logic       can_pop;
    logic       addr_ok;
    logic       timeout;
    logic       rsp_start;
    logic       rsp_len3;
    logic [7:0] rsp_b0, rsp_b1, rsp_b2;
    logic       rsp_done;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_trans;

    // A pop is never issued in the cycle right after one, so a stale rx_valid
    // from the receiver cannot cause a double pop.
    assign can_pop = bus.rx_valid && !pop;
    assign addr_ok = int'(addr) < REG_COUNT;

`ifdef SERIAL_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cycles;
    logic          waiting;

    assign waiting = (state == GET_ADDR) || (state == GET_DATA);
    assign timeout = waiting && (idle_cycles == TW'(TIMEOUT_CYCLES - 1));

    // Inter-byte counter: restarts on every pop, runs only while mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     idle_cycles <= '0;
        else if (pop_nxt || !waiting) idle_cycles <= '0;
        else                         idle_cycles <= idle_cycles + 1'b1;
    end
`else
    // Without the timeout the parser waits forever; the parameter is kept so
    // both builds share one instantiation.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Frame fields, strobes and the error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_write  <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            pop       <= 1'b0;
            we_strobe <= 1'b0;
            re_strobe <= 1'b0;
            err_count <= '0;
        end else begin
            is_write  <= is_write_nxt;
            addr      <= addr_nxt;
            wdata     <= wdata_nxt;
            pop       <= pop_nxt;
            we_strobe <= we_nxt;
            re_strobe <= re_nxt;
            if (err_inc) err_count <= sat_inc(err_count);
        end
    end

    // Next-state and control decode for the frame parser.
    always_comb begin
        state_nxt    = state;
        is_write_nxt = is_write;
        addr_nxt     = addr;
        wdata_nxt    = wdata;
        pop_nxt      = 1'b0;
        we_nxt       = 1'b0;
        re_nxt       = 1'b0;
        err_inc      = 1'b0;
        rsp_start    = 1'b0;
        rsp_len3     = 1'b0;
        rsp_b0       = RSP_ERR;
        rsp_b1       = 8'h00;
        rsp_b2       = 8'h00;
        case (state)
            IDLE: begin
                if (bus.rx_err) err_inc = 1'b1;
                if (can_pop) begin
                    pop_nxt = 1'b1;
                    if (bus.rx_data == OP_READ || bus.rx_data == OP_WRITE) begin
                        is_write_nxt = (bus.rx_data == OP_WRITE);
                        state_nxt    = GET_ADDR;
                    end else begin
                        rsp_start = 1'b1;
                        rsp_b1    = bus.rx_data;
                        err_inc   = 1'b1;
                        state_nxt = RESPOND;
                    end
                end
            end
            GET_ADDR: begin
                if (bus.rx_err || timeout) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end else if (can_pop) begin
                    pop_nxt   = 1'b1;
                    addr_nxt  = bus.rx_data;
                    state_nxt = is_write ? GET_DATA : REG_ACCESS;
                end
            end
            GET_DATA: begin
                if (bus.rx_err || timeout) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end else if (can_pop) begin
                    pop_nxt   = 1'b1;
                    wdata_nxt = bus.rx_data;
                    state_nxt = REG_ACCESS;
                end
            end
            REG_ACCESS: begin
                if (!addr_ok) begin
                    rsp_start = 1'b1;
                    rsp_b1    = addr;
                    err_inc   = 1'b1;
                    state_nxt = RESPOND;
                end else if (is_write) begin
                    we_nxt    = 1'b1;
                    rsp_start = 1'b1;
                    rsp_len3  = 1'b1;
                    rsp_b0    = RSP_ACK;
                    rsp_b1    = addr;
                    rsp_b2    = wdata;
                    state_nxt = RESPOND;
                end else begin
                    re_nxt    = 1'b1;
                    state_nxt = REG_WAIT;
                end
            end
            REG_WAIT: begin
                // First cycle here is the reg_re cycle; read data arrives one later.
                if (!re_strobe) begin
                    rsp_start = 1'b1;
                    rsp_len3  = 1'b1;
                    rsp_b0    = RSP_ACK;
                    rsp_b1    = addr;
                    rsp_b2    = bus.reg_rdata;
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    serial_resp_sender u_sender (
        .clk            (clk),
        .rst            (rst),
        .start          (rsp_start),
        .len3           (rsp_len3),
        .b0             (rsp_b0),
        .b1             (rsp_b1),
        .b2             (rsp_b2),
        .tx_data_copied (bus.tx_data_copied),
        .tx_data        (tx_data),
        .tx_data_ready  (tx_ready),
        .tx_transaction (tx_trans),
        .done           (rsp_done)
    );

    assign bus.rx_read        = pop;
    assign bus.reg_addr       = addr;
    assign bus.reg_wdata      = wdata;
    assign bus.reg_we         = we_strobe;
    assign bus.reg_re         = re_strobe;
    assign bus.tx_data        = tx_data;
    assign bus.tx_data_ready  = tx_ready;
    assign bus.tx_transaction = tx_trans;
    assign busy               = (state != IDLE);
    assign err_cnt            = err_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_cmd_sequencer
// Purpose  : Scoreboard bench for serial_cmd_sequencer: frames are pushed into
//            a receiver queue, a frame-level model queues expected register
//            accesses and response bytes, monitors pop and compare.
// Options  : SERIAL_CMD_TIMEOUT_EN selects the timeout scenario
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_cmd_sequencer;

    localparam int REG_COUNT = 16;
    localparam int TIMEOUT   = 64;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] err_cnt;

    serial_cmd_sequencer_if bus ();

    serial_cmd_sequencer #(
        .REG_COUNT      (REG_COUNT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] rxq[$];
    logic [7:0] exp_tx[$];
    acc_t       exp_acc[$];
    logic [7:0] model_mem[REG_COUNT];
    logic [7:0] bank[REG_COUNT];
    int         model_err = 0;
    bit         hold_copy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver FIFO: pop on rx_read, refresh head on the falling edge.
    always @(posedge clk) begin
        if (bus.rx_read && rxq.size() != 0) void'(rxq.pop_front());
    end
    always @(negedge clk) begin
        bus.rx_valid = (rxq.size() != 0);
        bus.rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    // Register bank: initial contents by index, one-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) bank[i] <= 8'(i * 29 + 3);
            bus.reg_rdata <= 8'h00;
        end else begin
            if (bus.reg_we) bank[bus.reg_addr[3:0]] <= bus.reg_wdata;
            if (bus.reg_re) bus.reg_rdata <= bank[bus.reg_addr[3:0]];
        end
    end

    // Transmitter: copies each ready byte after a random delay and scores it.
    initial begin
        bus.tx_data_copied = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_data_copied) begin
                bus.tx_data_copied = 1'b0;
            end else if (bus.tx_data_ready && !hold_copy && !rst && $urandom_range(0, 2) == 0) begin
                check("tx_transaction_during_byte", bus.tx_transaction, 1);
                if (exp_tx.size() == 0) check("tx_unexpected_byte", bus.tx_data, 32'hFFFF_FFFF);
                else                    check("tx_byte", bus.tx_data, exp_tx.pop_front());
                bus.tx_data_copied = 1'b1;
            end
        end
    end

    // Strobe, pop-spacing and timing monitor.
    int         last_pop_cyc = -10;
    int         ready_due    = -1;
    bit         prev_read    = 1'b0;
    bit         last_ready   = 1'b0;
    logic [7:0] last_data    = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.reg_we || bus.reg_re) begin
                if (exp_acc.size() == 0) begin
                    check("unexpected_strobe_addr", bus.reg_addr, 32'hFFFF_FFFF);
                end else begin
                    acc_t e;
                    e = exp_acc.pop_front();
                    check("strobe_kind", {bus.reg_we, bus.reg_re}, e.we ? 2'b10 : 2'b01);
                    check("strobe_addr", bus.reg_addr, e.addr);
                    if (e.we) check("strobe_wdata", bus.reg_wdata, e.data);
                end
                if (bus.reg_we) begin
                    check("we_after_last_pop", cyc - last_pop_cyc, 1);
                    ready_due = cyc + 1;
                end
            end
            if (ready_due == cyc) check("first_ready_after_we", bus.tx_data_ready, 1);
            if (bus.rx_read) begin
                check("rx_read_spacing", prev_read, 0);
                last_pop_cyc = cyc;
            end
            if (last_ready && bus.tx_data_ready) check("tx_data_stable", bus.tx_data, last_data);
        end
        prev_read  = bus.rx_read;
        last_ready = bus.tx_data_ready;
        last_data  = bus.tx_data;
    end

    // Frame-level reference: what each frame must produce.
    task automatic bump_err();
        if (model_err < 255) model_err++;
    endtask

    task automatic model_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
        if (op != 8'h52 && op != 8'h57) begin
            exp_tx.push_back(8'h45); exp_tx.push_back(op); bump_err();
        end else if (int'(a) >= REG_COUNT) begin
            exp_tx.push_back(8'h45); exp_tx.push_back(a); bump_err();
        end else if (op == 8'h57) begin
            exp_acc.push_back('{1'b1, a, d});
            model_mem[a[3:0]] = d;
            exp_tx.push_back(8'h41); exp_tx.push_back(a); exp_tx.push_back(d);
        end else begin
            exp_acc.push_back('{1'b0, a, 8'h00});
            exp_tx.push_back(8'h41); exp_tx.push_back(a); exp_tx.push_back(model_mem[a[3:0]]);
        end
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
        model_frame(op, a, d);
        rxq.push_back(op);
        if (op == 8'h52 || op == 8'h57) rxq.push_back(a);
        if (op == 8'h57) rxq.push_back(d);
    endtask

    task automatic reset_model();
        for (int i = 0; i < REG_COUNT; i++) model_mem[i] = 8'(i * 29 + 3);
        model_err = 0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0;
        int n     = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (rxq.size() == 0 && !busy && exp_tx.size() == 0) quiet++;
            else quiet = 0;
        end
        check({tag, "_drained"}, quiet >= 3, 1);
        check({tag, "_err_cnt"}, err_cnt, model_err);
        check({tag, "_tx_transaction_low"}, bus.tx_transaction, 0);
    endtask

    task automatic wait_rx_empty(input string tag);
        int n = 0;
        while (rxq.size() != 0 && n < 200) begin @(negedge clk); n++; end
        check({tag, "_rx_consumed"}, rxq.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        bus.rx_err = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_rx_read", bus.rx_read, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_tx_ready", bus.tx_data_ready, 0);
        check("rst_tx_transaction", bus.tx_transaction, 0);
        check("rst_reg_addr", bus.reg_addr, 0);
        check("rst_reg_wdata", bus.reg_wdata, 0);
        check("rst_strobes", {bus.reg_we, bus.reg_re}, 0);
        check("rst_busy", busy, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;

        send_frame(8'h57, 8'h03, 8'hA5);
        wait_idle("write", 500);
        send_frame(8'h57, 8'h02, 8'h5A);
        send_frame(8'h52, 8'h02, 8'h00);
        wait_idle("read_back", 500);
        send_frame(8'h11, 8'h00, 8'h00);
        wait_idle("bad_opcode", 500);
        send_frame(8'h52, 8'h00, 8'h00);
        wait_idle("read_after_bad_op", 500);
        send_frame(8'h57, 8'h20, 8'hFF);
        send_frame(8'h52, 8'h0F, 8'h00);
        send_frame(8'h52, 8'h10, 8'h00);
        wait_idle("addr_bounds", 500);

`ifdef SERIAL_CMD_TIMEOUT_EN
        rxq.push_back(8'h52);
        bump_err();
        repeat (TIMEOUT + 40) @(negedge clk);
        check("timeout_back_to_idle", busy, 0);
        wait_idle("timeout", 200);
`else
        model_frame(8'h52, 8'h07, 8'h00);
        rxq.push_back(8'h52);
        repeat (TIMEOUT + 40) @(negedge clk);
        check("no_timeout_still_busy", busy, 1);
        rxq.push_back(8'h07);
        wait_idle("late_byte", 500);
`endif

        rxq.push_back(8'h57);
        wait_rx_empty("abort");
        bump_err();
        bus.rx_err = 1'b1;
        @(negedge clk);
        bus.rx_err = 1'b0;
        @(negedge clk);
        check("abort_back_to_idle", busy, 0);
        wait_idle("abort", 200);

        bus.rx_err = 1'b1;
        bump_err();
        @(negedge clk);
        bus.rx_err = 1'b0;
        wait_idle("idle_rx_err", 200);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] op, a, d;
            a = 8'($urandom_range(0, 31));
            d = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 4))
                0:       begin
                             op = 8'($urandom_range(0, 255));
                             if (op == 8'h52 || op == 8'h57) op = 8'h00;
                         end
                1, 2:    op = 8'h52;
                default: op = 8'h57;
            endcase
            send_frame(op, a, d);
        end
        wait_idle("random", 5000);

        hold_copy = 1'b1;
        send_frame(8'h52, 8'h03, 8'h00);
        begin
            int n = 0;
            while (!bus.tx_data_ready && n < 200) begin @(negedge clk); n++; end
            check("reset_test_ready_seen", bus.tx_data_ready, 1);
        end
        #2 rst = 1'b1;
        #1;
        check("reset_drops_ready", bus.tx_data_ready, 0);
        check("reset_drops_transaction", bus.tx_transaction, 0);
        check("reset_drops_busy", busy, 0);
        check("reset_clears_err_cnt", err_cnt, 0);
        exp_tx.delete();
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        hold_copy = 1'b0;
        send_frame(8'h52, 8'h05, 8'h00);
        wait_idle("after_reset", 500);

        for (int i = 0; i < 260; i++) send_frame(8'h11 + 8'(i % 3), 8'h00, 8'h00);
        wait_idle("saturate", 20000);
        check("err_cnt_saturated", err_cnt, 255);

        check("leftover_tx", exp_tx.size(), 0);
        check("leftover_strobes", exp_acc.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/serial_cmd_sequencer.md
# serial_cmd_sequencer

Command sequencer between the RS232 byte channel of `quick_rs232` and an internal register bank. It pops received bytes and parses 2- or 3-byte read/write frames. It issues one register access per frame, then streams a 3-byte acknowledge or 2-byte error response back through the transmitter handshake. It fills the main processing loop of the serial command processor top level.

## Interface
- `REG_COUNT`, 16: number of addressable registers; valid addresses are 0..REG_COUNT-1.
- `TIMEOUT_CYCLES`, 5000000: inter-byte timeout (100 ms at 50 MHz). Used only with the timeout macro.
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `rx_valid`  in  1  received byte available (level).
- `rx_data`  in  8  byte at the head of the receiver; valid while `rx_valid` is high.
- `rx_err`  in  1  parity/framing error pulse from the receiver.
- `rx_read`  out  1  one-cycle pop of the head byte.
- `tx_data`  out  8  response byte.
- `tx_data_ready`  out  1  `tx_data` valid; held until `tx_data_copied`.
- `tx_data_copied`  in  1  transmitter has latched `tx_data`.
- `tx_transaction`  out  1  high for the whole response.
- `reg_addr`  out  8  register address.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_re`.
- `busy`  out  1  state is not IDLE.
- `err_cnt`  out  8  saturating count of rejected or aborted frames.

## Operation
- Frames:
  - Read: 0x52 'R', addr.
  - Write: 0x57 'W', addr, data.
- Responses:
  - Acknowledge: 0x41 'A', addr, data. Data is the value read, or the value written.
  - Error: 0x45 'E', offending byte.
- States: IDLE, GET_ADDR, GET_DATA, REG_ACCESS, REG_WAIT, SEND_BYTE, WAIT_COPY.
- IDLE
  - On `rx_valid`, pop and latch the opcode.
  - 'R' → GET_ADDR. 'W' → GET_ADDR.
  - Any other byte → error response carrying that byte, `err_cnt`+1.
- GET_ADDR: pop the address. Read → REG_ACCESS. Write → GET_DATA.
- GET_DATA: pop the data byte → REG_ACCESS.
- REG_ACCESS
  - addr ≥ REG_COUNT → error response carrying addr; no strobe; `err_cnt`+1.
  - Otherwise pulse `reg_we` (write, then go to the response) or `reg_re` (read, then REG_WAIT).
- REG_WAIT: latch `reg_rdata`, build the acknowledge.
- SEND_BYTE: drive `tx_data`, raise `tx_data_ready` → WAIT_COPY.
- WAIT_COPY
  - On `tx_data_copied`, drop `tx_data_ready`.
  - Next byte → SEND_BYTE. After the last byte → IDLE and drop `tx_transaction`.
- `rx_err` high in GET_ADDR or GET_DATA aborts the frame: → IDLE, no response, `err_cnt`+1.
- `rx_err` high in IDLE: `err_cnt`+1 only.
- No new bytes are popped while a response is in progress; they stay queued in the receiver.
- `err_cnt` saturates at 255; it never wraps.

## Timing
- Reset values: all outputs 0, `err_cnt` 0, state IDLE. Reset mid-frame or mid-response drops everything immediately, including `tx_data_ready`.
- `rx_read` is a single-cycle pulse. It is never asserted in two consecutive cycles, which allows for a stale `rx_valid`.
- `rx_data` is latched in the same cycle as `rx_read`.
- `reg_addr` and `reg_wdata` are stable in the strobe cycle and remain stable until the next frame.
- Read latency: `reg_re` at cycle N, `reg_rdata` sampled at N+1.
- `tx_data_ready` stays low for at least one cycle between bytes.
- `tx_data` is stable while `tx_data_ready` is high.
- If `tx_data_copied` arrives in the same cycle as `rx_valid`, the byte is not popped.
- Write frame, byte 3 popped at cycle N: `reg_we` at N+1, first `tx_data_ready` at N+2.

## Configuration
- `SERIAL_CMD_TIMEOUT_EN` defined:
  - A counter clears on every pop and counts in GET_ADDR and GET_DATA.
  - Reaching TIMEOUT_CYCLES-1 → IDLE, no response, `err_cnt`+1.
- Undefined: no counter; the parser waits indefinitely for the next byte.

## Structure
- Package `serial_cmd_pkg`: opcode and response constants (0x52, 0x57, 0x41, 0x45) and the state encoding localparams.
- Sub-module `serial_resp_sender`:
  - Holds a 3-byte response buffer and a length of 2 or 3.
  - Owns SEND_BYTE/WAIT_COPY and the tx handshake.
  - Signals `done` to the sequencer.

## Test plan
- Write: send 57 03 A5 → `reg_we` for one cycle with addr 03 and data A5; tx sequence 41 03 A5; `err_cnt` stays 0.
- Read: send 52 02 with `reg_rdata`=5A → one `reg_re` pulse; tx 41 02 5A.
- Bad opcode: send 11 → tx 45 11, no strobes, `err_cnt`=1. A following 52 00 is then served normally.
- Bad address: with REG_COUNT=16, send 57 20 FF → tx 45 20, no `reg_we`, `err_cnt`+1.
- Timeout: with the macro defined, send 52 then idle for TIMEOUT_CYCLES → IDLE with no tx, `err_cnt`+1. Without the macro, a late 07 is still served as a read of addr 07.
- Reset during WAIT_COPY with `tx_data_copied` withheld → `tx_data_ready`, `tx_transaction` and `busy` all 0 in the same cycle.
